// File: rtl/ccd_timing_ctrl_pkg.sv
// Shared definitions for the linear-CCD line timing sequencer and the AD9945 sampling driver.
// Optional line counter is enabled by defining CCD_LINE_CNT_EN.
package ccd_pkg;

    localparam int unsigned PIX_NUM_DEF   = 2048;
    localparam int unsigned DUMMY_NUM_DEF = 10;

    typedef enum logic [2:0] {
        IDLE,
        SH_SETUP,
        SH_PULSE,
        SH_HOLD,
        SHIFT,
        WAIT
    } ccd_state_t;

    // Shortest legal line: guarded transfer pulse followed by a complete shift-out.
    function automatic int unsigned t_min(input int unsigned sh_guard,
                                          input int unsigned sh_width,
                                          input int unsigned dummy_num,
                                          input int unsigned pix_num,
                                          input int unsigned f_half);
        return 2 * sh_guard + sh_width + (dummy_num + pix_num) * 2 * f_half;
    endfunction

endpackage

// File: rtl/ccd_timing_ctrl_if.sv
// Control/status and CCD drive bundle of ccd_timing_ctrl.
// line_cnt exists only when CCD_LINE_CNT_EN is defined.
interface ccd_timing_ctrl_if #(
    parameter int unsigned INT_W = 24
);
    logic             start;
    logic             cont_mode;
    logic [INT_W-1:0] int_time;
    logic             busy;
    logic             sh;
    logic             f1;
    logic             f2;
    logic             rs;
    logic             line_done;
`ifdef CCD_LINE_CNT_EN
    logic [15:0]      line_cnt;
`endif

    modport master (
`ifdef CCD_LINE_CNT_EN
        input  line_cnt,
`endif
        output start, cont_mode, int_time,
        input  busy, sh, f1, f2, rs, line_done
    );

    modport slave (
`ifdef CCD_LINE_CNT_EN
        output line_cnt,
`endif
        input  start, cont_mode, int_time,
        output busy, sh, f1, f2, rs, line_done
    );

endinterface

// File: rtl/ccd_timing_ctrl_pix_clkgen.sv
// Pixel-phase counter and f1/f2/rs decode for the SHIFT segment of a CCD line.
// en is the *next-cycle* shift qualifier so all outputs come straight from flops.
module ccd_pix_clkgen #(
    parameter int unsigned F_HALF     = 10,
    parameter int unsigned RS_P_WIDTH = 2
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic en,
    input  logic f1_hold,
    output logic f1,
    output logic f2,
    output logic rs
);

    localparam int unsigned PH_W = $clog2(2 * F_HALF) + 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * F_HALF - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(F_HALF);
    localparam logic [PH_W-1:0] PH_RS   = PH_W'(RS_P_WIDTH);

    logic            active;
    logic [PH_W-1:0] ph;
    logic [PH_W-1:0] ph_next;

    // Phase restarts at 0 on SHIFT entry so the first cycle carries an f2 rise.
    always_comb begin
        ph_next = '0;
        if (en && active)
            ph_next = (ph == PH_LAST) ? '0 : ph + PH_W'(1);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            ph     <= '0;
            f1     <= 1'b0;
            f2     <= 1'b0;
            rs     <= 1'b0;
        end else begin
            active <= en;
            ph     <= ph_next;
            if (en) begin
                f2 <= (ph_next < PH_HALF);
                f1 <= !(ph_next < PH_HALF);
                rs <= (ph_next < PH_RS);
            end else begin
                f2 <= 1'b0;
                f1 <= f1_hold;
                rs <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ccd_timing_ctrl.sv
// Linear-CCD line timing sequencer: sh transfer gate, f1/f2 shift clocks and rs reset gate.
// Define CCD_LINE_CNT_EN to add the 16-bit completed-line counter output.
module ccd_timing_ctrl
    import ccd_pkg::*;
#(
    parameter int unsigned PIX_NUM    = PIX_NUM_DEF,
    parameter int unsigned DUMMY_NUM  = DUMMY_NUM_DEF,
    parameter int unsigned F_HALF     = 10,
    parameter int unsigned RS_P_WIDTH = 2,
    parameter int unsigned SH_WIDTH   = 100,
    parameter int unsigned SH_GUARD   = 20,
    parameter int unsigned INT_W      = 24
) (
    input  logic               sys_clk,
    input  logic               rst,
    ccd_timing_ctrl_if.slave   bus
);

    localparam int unsigned T_MIN = t_min(SH_GUARD, SH_WIDTH, DUMMY_NUM, PIX_NUM, F_HALF);

    localparam logic [INT_W-1:0] SETUP_END = INT_W'(SH_GUARD - 1);
    localparam logic [INT_W-1:0] PULSE_END = INT_W'(SH_GUARD + SH_WIDTH - 1);
    localparam logic [INT_W-1:0] HOLD_END  = INT_W'(2 * SH_GUARD + SH_WIDTH - 1);
    localparam logic [INT_W-1:0] SHIFT_END = INT_W'(T_MIN - 1);

    ccd_state_t       state, state_next;
    logic [INT_W-1:0] lc, lc_next;
    logic [INT_W-1:0] lp_req, lp_req_next;
    logic [INT_W-1:0] lp_m1;
    logic             line_end;
    logic             sh_d, busy_d, line_done_d, f1_hold, shift_en;
    logic             sh_q, busy_q, line_done_q;
    logic             f1_w, f2_w, rs_w;

    assign lp_m1    = (lp_req > SHIFT_END) ? lp_req - INT_W'(1) : SHIFT_END;
    // lc only reaches lp_m1 inside SHIFT on its last cycle, since LP >= T_MIN.
    assign line_end = ((state == SHIFT) || (state == WAIT)) && (lc == lp_m1);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lc          <= '0;
            lp_req      <= '0;
            sh_q        <= 1'b0;
            busy_q      <= 1'b0;
            line_done_q <= 1'b0;
        end else begin
            state       <= state_next;
            lc          <= lc_next;
            lp_req      <= lp_req_next;
            sh_q        <= sh_d;
            busy_q      <= busy_d;
            line_done_q <= line_done_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (bus.start)         state_next = SH_SETUP;
            SH_SETUP: if (lc == SETUP_END)   state_next = SH_PULSE;
            SH_PULSE: if (lc == PULSE_END)   state_next = SH_HOLD;
            SH_HOLD:  if (lc == HOLD_END)    state_next = SHIFT;
            SHIFT: begin
                if (line_end)                state_next = bus.cont_mode ? SH_SETUP : IDLE;
                else if (lc == SHIFT_END)    state_next = WAIT;
            end
            WAIT:     if (line_end)          state_next = bus.cont_mode ? SH_SETUP : IDLE;
            default:                         state_next = IDLE;
        endcase

        lc_next     = lc + INT_W'(1);
        lp_req_next = lp_req;
        if ((state_next == SH_SETUP) && (state != SH_SETUP)) begin
            lc_next     = '0;
            lp_req_next = bus.int_time;
        end
    end

    // Outputs are decoded from the next state so every pin is a flop aligned with its state.
    always_comb begin
        sh_d        = (state_next == SH_PULSE);
        busy_d      = (state_next != IDLE);
        shift_en    = (state_next == SHIFT);
        f1_hold     = (state_next inside {SH_SETUP, SH_PULSE, SH_HOLD, WAIT});
        line_done_d = ((state_next == SHIFT) || (state_next == WAIT)) && (lc_next == lp_m1);
    end

    ccd_pix_clkgen #(
        .F_HALF     (F_HALF),
        .RS_P_WIDTH (RS_P_WIDTH)
    ) u_pix_clkgen (
        .sys_clk (sys_clk),
        .rst     (rst),
        .en      (shift_en),
        .f1_hold (f1_hold),
        .f1      (f1_w),
        .f2      (f2_w),
        .rs      (rs_w)
    );

    assign bus.sh        = sh_q;
    assign bus.f1        = f1_w;
    assign bus.f2        = f2_w;
    assign bus.rs        = rs_w;
    assign bus.busy      = busy_q;
    assign bus.line_done = line_done_q;

`ifdef CCD_LINE_CNT_EN
    logic [15:0] line_cnt_q;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            line_cnt_q <= '0;
        else if ((state == IDLE) && bus.start)
            line_cnt_q <= '0;
        else if (line_done_q)
            line_cnt_q <= line_cnt_q + 16'd1;
    end

    assign bus.line_cnt = line_cnt_q;
`endif

endmodule

// File: tb/tb_ccd_timing_ctrl.sv
// Self-checking bench for ccd_timing_ctrl using a line-offset reference model.
// Also checks line_cnt when CCD_LINE_CNT_EN is defined.
module tb_ccd_timing_ctrl;

    localparam int G    = 2;
    localparam int W    = 4;
    localparam int D    = 2;
    localparam int P    = 16;
    localparam int F    = 2;
    localparam int RSW  = 1;
    localparam int TMIN = 2 * G + W + (D + P) * 2 * F;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;

    int compared   = 0;
    int mismatched = 0;

    ccd_timing_ctrl_if #(.INT_W(24)) bus ();

    ccd_timing_ctrl #(
        .PIX_NUM    (P),
        .DUMMY_NUM  (D),
        .F_HALF     (F),
        .RS_P_WIDTH (RSW),
        .SH_WIDTH   (W),
        .SH_GUARD   (G),
        .INT_W      (24)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: whether a line is running, offset within it, and its period.
    bit m_on  = 1'b0;
    int m_t   = 0;
    int m_lp  = TMIN;
    int m_cnt = 0;

    function automatic int lp_of(input int it);
        return (it > TMIN) ? it : TMIN;
    endfunction

    always @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            m_on  <= 1'b0;
            m_t   <= 0;
            m_cnt <= 0;
        end else if (!m_on) begin
            if (bus.start) begin
                m_on  <= 1'b1;
                m_t   <= 0;
                m_lp  <= lp_of(int'(bus.int_time));
                m_cnt <= 0;
            end
        end else if (m_t == m_lp - 1) begin
            m_cnt <= (m_cnt + 1) % 65536;
            if (bus.cont_mode) begin
                m_t  <= 0;
                m_lp <= lp_of(int'(bus.int_time));
            end else begin
                m_on <= 1'b0;
            end
        end else begin
            m_t <= m_t + 1;
        end
    end

    // Expected {busy, sh, f1, f2, rs, line_done} for the current model position.
    function automatic logic [5:0] model_vec();
        logic sh, f1, f2, rs, ld;
        int p;
        sh = 1'b0; f1 = 1'b0; f2 = 1'b0; rs = 1'b0; ld = 1'b0;
        if (!m_on) return 6'b0;
        if (m_t < G + W) begin
            f1 = 1'b1;
            sh = (m_t >= G);
        end else if (m_t < 2 * G + W) begin
            f1 = 1'b1;
        end else if (m_t < TMIN) begin
            p  = (m_t - (2 * G + W)) % (2 * F);
            f2 = (p < F);
            rs = (p < RSW);
            f1 = !f2;
        end else begin
            f1 = 1'b1;
        end
        ld = (m_t == m_lp - 1);
        return {1'b1, sh, f1, f2, rs, ld};
    endfunction

    // Per-cycle invariants plus shift-pulse count per completed line.
    logic pf2 = 1'b0, psh = 1'b0;
    int   rises = 0;
    always @(negedge sys_clk) begin
        if (rst) begin
            pf2 = 1'b0; psh = 1'b0; rises = 0;
        end else begin
            compared++;
            if ((bus.f1 && bus.f2) || (bus.sh && bus.f2) || (bus.rs && !bus.f2)) begin
                mismatched++;
                $display("FAIL invariant at %0t: f1=%b f2=%b sh=%b rs=%b, required f1&f2=0 sh&f2=0 rs->f2",
                         $time, bus.f1, bus.f2, bus.sh, bus.rs);
            end
            if (bus.sh && !psh) rises = 0;
            if (bus.f2 && !pf2) rises++;
            if (bus.line_done) begin
                compared++;
                if (rises - D != P) begin
                    mismatched++;
                    $display("FAIL tvalid_count at %0t: got %0d pixels, expected %0d", $time, rises - D, P);
                end
            end
            pf2 = bus.f2;
            psh = bus.sh;
        end
    end

    task automatic test_reset();
        logic [5:0] got;
        bus.start = 1'b0; bus.cont_mode = 1'b0; bus.int_time = '0;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge sys_clk);
            got = {bus.busy, bus.sh, bus.f1, bus.f2, bus.rs, bus.line_done};
            compared++;
            if (got !== 6'b0) begin
                mismatched++;
                $display("FAIL reset cyc %0d: got %b, expected 000000", k, got);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [5:0] got, exp;
        int sh_first = -1, sh_last = -1, nrise = 0, ld_at = -1, busy_low = -1;
        logic lf2 = 1'b0;
        bus.cont_mode = 1'b0; bus.int_time = '0; bus.start = 1'b1;
        for (int k = 0; k < 90; k++) begin
            @(negedge sys_clk);
            bus.start = 1'b0;
            got = {bus.busy, bus.sh, bus.f1, bus.f2, bus.rs, bus.line_done};
            exp = model_vec();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL single cyc %0d: got %b, expected %b", k, got, exp);
            end
            if (bus.sh) begin
                if (sh_first < 0) sh_first = k;
                sh_last = k;
            end
            if (bus.f2 && !lf2) nrise++;
            lf2 = bus.f2;
            if (bus.line_done && ld_at < 0) ld_at = k;
            if (!bus.busy && busy_low < 0) busy_low = k;
        end
        compared += 5;
        if (sh_first != G) begin mismatched++; $display("FAIL single_sh_first: got %0d, expected %0d", sh_first, G); end
        if (sh_last != G + W - 1) begin mismatched++; $display("FAIL single_sh_last: got %0d, expected %0d", sh_last, G + W - 1); end
        if (nrise != D + P) begin mismatched++; $display("FAIL single_f2_rises: got %0d, expected %0d", nrise, D + P); end
        if (ld_at != TMIN - 1) begin mismatched++; $display("FAIL single_line_done: got %0d, expected %0d", ld_at, TMIN - 1); end
        if (busy_low != TMIN) begin mismatched++; $display("FAIL single_busy_low: got %0d, expected %0d", busy_low, TMIN); end
    endtask

    task automatic test_period(input string name, input int it, input int run, input int exp_gap, input int exp_n);
        logic [5:0] got, exp;
        int q[$];
        logic lsh = 1'b0;
        bus.cont_mode = 1'b1; bus.int_time = 24'(it); bus.start = 1'b1;
        for (int k = 0; k < run + 2 * lp_of(it); k++) begin
            @(negedge sys_clk);
            bus.start = 1'b0;
            if (k == run) bus.cont_mode = 1'b0;
            got = {bus.busy, bus.sh, bus.f1, bus.f2, bus.rs, bus.line_done};
            exp = model_vec();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL %s cyc %0d: got %b, expected %b", name, k, got, exp);
            end
            if (bus.sh && !lsh && k < run) q.push_back(k);
            lsh = bus.sh;
        end
        compared++;
        if (q.size() != exp_n) begin
            mismatched++;
            $display("FAIL %s_sh_count: got %0d, expected %0d", name, q.size(), exp_n);
        end
        for (int i = 1; i < q.size(); i++) begin
            compared++;
            if (q[i] - q[i-1] != exp_gap) begin
                mismatched++;
                $display("FAIL %s_sh_gap[%0d]: got %0d, expected %0d", name, i, q[i] - q[i-1], exp_gap);
            end
        end
        compared++;
        if (bus.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_idle: got busy=%b, expected 0", name, bus.busy);
        end
    endtask

    task automatic test_stop_midline();
        logic [5:0] got, exp;
        int lp, n, nld;
        lp = $urandom_range(TMIN, 130);
        n  = $urandom_range(lp + 5, 2 * lp);
        bus.cont_mode = 1'b1; bus.int_time = 24'(lp); bus.start = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge sys_clk);
            bus.start = 1'b0;
        end
        if (bus.line_done) @(negedge sys_clk);
        bus.cont_mode = 1'b0;
        nld = 0;
        for (int k = 0; k < 2 * lp + 5; k++) begin
            @(negedge sys_clk);
            got = {bus.busy, bus.sh, bus.f1, bus.f2, bus.rs, bus.line_done};
            exp = model_vec();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL stop cyc %0d: got %b, expected %b", k, got, exp);
            end
            if (bus.line_done) nld++;
        end
        compared += 2;
        if (nld != 1) begin mismatched++; $display("FAIL stop_line_done_count: got %0d, expected 1", nld); end
        if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL stop_idle: got busy=%b, expected 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        logic [5:0] got, exp;
        int sh_first = -1;
        bus.cont_mode = 1'b0; bus.int_time = '0; bus.start = 1'b1;
        for (int k = 0; k <= 2 * G + W + 7 * 2 * F + 1; k++) begin
            @(negedge sys_clk);
            bus.start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        got = {bus.busy, bus.sh, bus.f1, bus.f2, bus.rs, bus.line_done};
        compared++;
        if (got !== 6'b0) begin
            mismatched++;
            $display("FAIL reset_mid_async: got %b, expected 000000", got);
        end
        @(negedge sys_clk);
        @(negedge sys_clk);
        rst = 1'b0;
        bus.start = 1'b1;
        for (int k = 0; k < 90; k++) begin
            @(negedge sys_clk);
            bus.start = 1'b0;
            got = {bus.busy, bus.sh, bus.f1, bus.f2, bus.rs, bus.line_done};
            exp = model_vec();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL reset_mid cyc %0d: got %b, expected %b", k, got, exp);
            end
            if (bus.sh && sh_first < 0) sh_first = k;
        end
        compared++;
        if (sh_first != G) begin
            mismatched++;
            $display("FAIL reset_mid_sh_first: got %0d, expected %0d", sh_first, G);
        end
    endtask

    task automatic test_random();
        logic [5:0] got, exp;
        bus.cont_mode = 1'b0; bus.int_time = '0; bus.start = 1'b0;
        for (int k = 0; k < 3200; k++) begin
            @(negedge sys_clk);
            got = {bus.busy, bus.sh, bus.f1, bus.f2, bus.rs, bus.line_done};
            exp = model_vec();
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL random cyc %0d: got %b, expected %b", k, got, exp);
            end
`ifdef CCD_LINE_CNT_EN
            compared++;
            if (int'(bus.line_cnt) != m_cnt) begin
                mismatched++;
                $display("FAIL random_line_cnt cyc %0d: got %0d, expected %0d", k, bus.line_cnt, m_cnt);
            end
`endif
            if (k < 3000) begin
                bus.start = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 9) == 0) bus.int_time = 24'($urandom_range(0, 160));
                if ($urandom_range(0, 149) == 0) bus.cont_mode = !bus.cont_mode;
            end else begin
                bus.start = 1'b0;
                bus.cont_mode = 1'b0;
            end
        end
        compared++;
        if (bus.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL random_idle: got busy=%b, expected 0", bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_period("cont200", 200, 650, 200, 4);
        test_period("short50", 50, 250, TMIN, 4);
        test_stop_midline();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
